// File: rtl/and_gate_stimulus_driver.sv
// Stimulus source for a bubble-masked N-input AND gate: exhaustive counter or Galois LFSR vectors
// over a valid/ready handshake. Define STIM_CHECKER_EN to add the Result_In mismatch counter.
module and_gate_stimulus_driver #(
  parameter int                      NR_OF_INPUTS = 5,
  parameter logic [NR_OF_INPUTS-1:0] BUBBLES_MASK = '0,
  parameter logic [NR_OF_INPUTS-1:0] LFSR_TAPS    = 5'b10100
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic                    Mode,
  input  logic [NR_OF_INPUTS-1:0] Seed,
  input  logic [7:0]              Length,
  input  logic                    Vec_Ready,
  input  logic                    Result_In,
  output logic [NR_OF_INPUTS-1:0] Input_Vector,
  output logic                    Expected_Result,
  output logic                    Vec_Valid,
  output logic                    Busy,
  output logic                    Done,
  output logic [7:0]              Error_Count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Wide enough for both 2^N (exhaustive) and 256 (LFSR with Length = 0).
  localparam int CNT_W = (NR_OF_INPUTS + 1 > 9) ? NR_OF_INPUTS + 1 : 9;

  logic [1:0]              state;
  logic                    mode_q;
  logic [NR_OF_INPUTS-1:0] vec;
  logic [NR_OF_INPUTS-1:0] vec_next;
  logic [CNT_W-1:0]        remaining;
  logic [CNT_W-1:0]        exh_load;
  logic [CNT_W-1:0]        len_load;
  logic [NR_OF_INPUTS-1:0] seed_load;
  logic                    start_ok;
  logic                    transfer;

  assign exh_load  = CNT_W'(1) << NR_OF_INPUTS;
  assign len_load  = (Length == 8'd0) ? CNT_W'(256) : CNT_W'(Length);
  assign seed_load = (Seed == '0) ? NR_OF_INPUTS'(1) : Seed;
  assign start_ok  = Start && (state != RUN);
  assign transfer  = Vec_Valid && Vec_Ready;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    vec_next = vec + NR_OF_INPUTS'(1);
    if (mode_q) begin
      vec_next = {1'b0, vec[NR_OF_INPUTS-1:1]} ^ (vec[0] ? LFSR_TAPS : '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      vec       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state     <= RUN;
            mode_q    <= Mode;
            vec       <= Mode ? seed_load : '0;
            remaining <= Mode ? len_load : exh_load;
          end
        end
        RUN: begin
          if (transfer) begin
            remaining <= remaining - CNT_W'(1);
            // The last vector stays on the bus; the counter never presents its wrap to 0.
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end else begin
              vec <= vec_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Input_Vector    = vec;
  assign Expected_Result = &(vec ^ BUBBLES_MASK);
  assign Vec_Valid       = (state == RUN);
  assign Busy            = (state == RUN);
  assign Done            = (state == DONE);

`ifdef STIM_CHECKER_EN
  logic [7:0] err_cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      err_cnt <= 8'd0;
    end else if (start_ok) begin
      err_cnt <= 8'd0;
    end else if (transfer && (Result_In != Expected_Result) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign Error_Count = err_cnt;
`else
  logic unused_checker;
  assign unused_checker = Result_In ^ start_ok;
  assign Error_Count    = 8'd0;
`endif

endmodule

// File: tb/tb_and_gate_stimulus_driver.sv
// Directed bench for and_gate_stimulus_driver: reset, exhaustive, bubble mask, LFSR, stalls,
// mid-run reset and (with STIM_CHECKER_EN) the mismatch counter.
module tb_and_gate_stimulus_driver;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       Start, start1, Mode, Vec_Ready, Result_In;
  logic [4:0] Seed;
  logic [7:0] Length;

  logic [4:0] vec0, vec1;
  logic       exp0, exp1, valid0, valid1, busy0, busy1, done0, done1;
  logic [7:0] err0, err1;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  and_gate_stimulus_driver #(.NR_OF_INPUTS(5), .BUBBLES_MASK(5'b00000), .LFSR_TAPS(5'b10100)) dut0 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Mode(Mode), .Seed(Seed), .Length(Length),
    .Vec_Ready(Vec_Ready), .Result_In(Result_In), .Input_Vector(vec0), .Expected_Result(exp0),
    .Vec_Valid(valid0), .Busy(busy0), .Done(done0), .Error_Count(err0));

  and_gate_stimulus_driver #(.NR_OF_INPUTS(5), .BUBBLES_MASK(5'b00011), .LFSR_TAPS(5'b10100)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(start1), .Mode(Mode), .Seed(Seed), .Length(Length),
    .Vec_Ready(Vec_Ready), .Result_In(Result_In), .Input_Vector(vec1), .Expected_Result(exp1),
    .Vec_Valid(valid1), .Busy(busy1), .Done(done1), .Error_Count(err1));

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_run(input logic mode, input logic [4:0] seed, input logic [7:0] len);
    Mode = mode; Seed = seed; Length = len; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({vec0, exp0, valid0, busy0, done0, err0} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got vec=%0d exp=%b valid=%b busy=%b done=%b err=%0d, want all 0",
               vec0, exp0, valid0, busy0, done0, err0);
    end
    vectors++;
    if (exp1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_expected_masked: got %b want 0", exp1);
    end
  endtask

  task automatic test_exhaustive();
    int bad = 0;
    Vec_Ready = 1'b1;
    Result_In = 1'b0;
    start_run(1'b0, 5'd0, 8'd0);
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (valid0 !== 1'b1 || busy0 !== 1'b1 || vec0 !== 5'(i) || exp0 !== (i == 31)) begin
        miscompares++; bad++;
        if (bad < 5)
          $display("FAIL exhaustive_vec%0d: got vec=%0d exp=%b valid=%b want vec=%0d exp=%b valid=1",
                   i, vec0, exp0, valid0, i, (i == 31));
      end
      tick();
    end
    vectors++;
    if (done0 !== 1'b1 || valid0 !== 1'b0 || busy0 !== 1'b0 || vec0 !== 5'd31) begin
      miscompares++;
      $display("FAIL exhaustive_done: got done=%b valid=%b busy=%b vec=%0d want 1 0 0 31",
               done0, valid0, busy0, vec0);
    end
`ifndef STIM_CHECKER_EN
    vectors++;
    if (err0 !== 8'd0) begin
      miscompares++;
      $display("FAIL error_count_tied: got %0d want 0", err0);
    end
`endif
  endtask

  task automatic test_bubbles();
    int bad = 0;
    Vec_Ready = 1'b1;
    Mode = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (vec1 !== 5'(i) || exp1 !== (i == 28)) begin
        miscompares++; bad++;
        if (bad < 5)
          $display("FAIL bubbles_vec%0d: got vec=%0d exp=%b want vec=%0d exp=%b",
                   i, vec1, exp1, i, (i == 28));
      end
      tick();
    end
    vectors++;
    if (done1 !== 1'b1) begin
      miscompares++;
      $display("FAIL bubbles_done: got %b want 1", done1);
    end
  endtask

  task automatic test_lfsr();
    logic [4:0] want [3] = '{5'd1, 5'd20, 5'd10};
    Vec_Ready = 1'b1;
    start_run(1'b1, 5'd0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (valid0 !== 1'b1 || vec0 !== want[i]) begin
        miscompares++;
        $display("FAIL lfsr_vec%0d: got vec=%0d valid=%b want vec=%0d valid=1", i, vec0, valid0, want[i]);
      end
      tick();
    end
    vectors++;
    if (done0 !== 1'b1 || valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL lfsr_done: got done=%b valid=%b want 1 0", done0, valid0);
    end
  endtask

  task automatic test_lfsr_length_256();
    bit zero_seen = 0;
    Vec_Ready = 1'b1;
    start_run(1'b1, 5'd1, 8'd0);
    for (int i = 0; i < 256; i++) begin
      if (vec0 == 5'd0) zero_seen = 1;
      if (i == 31) begin
        vectors++;
        if (vec0 !== 5'd1) begin
          miscompares++;
          $display("FAIL lfsr_period: got vec=%0d at step 31 want 1", vec0);
        end
      end
      if (i == 255) begin
        vectors++;
        if (valid0 !== 1'b1 || done0 !== 1'b0) begin
          miscompares++;
          $display("FAIL lfsr_len256_last: got valid=%b done=%b want 1 0", valid0, done0);
        end
      end
      tick();
    end
    vectors++;
    if (zero_seen || done0 !== 1'b1) begin
      miscompares++;
      $display("FAIL lfsr_len256_end: got zero_seen=%b done=%b want 0 1", zero_seen, done0);
    end
  endtask

  task automatic test_stall_and_reset();
    Vec_Ready = 1'b0;
    start_run(1'b0, 5'd0, 8'd0);
    Vec_Ready = 1'b1;
    tick();
    Vec_Ready = 1'b0;
    tick();
    vectors++;
    if (vec0 !== 5'd1 || valid0 !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_hold1: got vec=%0d valid=%b want 1 1", vec0, valid0);
    end
    Start = 1'b1; Mode = 1'b1; Seed = 5'd7;
    tick();
    Start = 1'b0;
    vectors++;
    if (vec0 !== 5'd1 || valid0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_start_ignored: got vec=%0d valid=%b busy=%b done=%b want 1 1 1 0",
               vec0, valid0, busy0, done0);
    end
    Vec_Ready = 1'b1;
    tick();
    Vec_Ready = 1'b0;
    vectors++;
    if (vec0 !== 5'd2 || valid0 !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_advance: got vec=%0d valid=%b want 2 1", vec0, valid0);
    end
    Reset_n = 1'b0;
    tick();
    vectors++;
    if ({vec0, valid0, busy0, done0, err0} !== {5'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL midrun_reset: got vec=%0d valid=%b busy=%b done=%b err=%0d want all 0",
               vec0, valid0, busy0, done0, err0);
    end
    Reset_n = 1'b1;
    tick();
  endtask

`ifdef STIM_CHECKER_EN
  task automatic test_checker();
    logic [7:0] want [2] = '{8'd1, 8'd31};
    Vec_Ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      Result_In = 1'(r);
      start_run(1'b0, 5'd0, 8'd0);
      repeat (32) tick();
      vectors++;
      if (done0 !== 1'b1 || err0 !== want[r]) begin
        miscompares++;
        $display("FAIL checker_result%0d: got done=%b err=%0d want 1 %0d", r, done0, err0, want[r]);
      end
    end
    Result_In = 1'b0;
  endtask
`endif

  initial begin
    Reset_n = 1'b0; Start = 1'b0; start1 = 1'b0; Mode = 1'b0;
    Seed = 5'd0; Length = 8'd0; Vec_Ready = 1'b0; Result_In = 1'b0;
    repeat (2) tick();
    test_reset();
    Reset_n = 1'b1;
    tick();
    test_exhaustive();
    test_bubbles();
    test_lfsr();
    test_lfsr_length_256();
    test_stall_and_reset();
`ifdef STIM_CHECKER_EN
    test_checker();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
